// File: rtl/input_conditioner_pkg.sv
// Shared helpers and limits for the multi-channel input conditioner.
package input_conditioner_pkg;

  localparam int unsigned min_width_lp       = 1;
  localparam int unsigned min_sync_stages_lp = 2;
  localparam int unsigned min_debounce_lp    = 1;

  // The counter only has to reach debounce_cycles-1, but it is sized for the full value
  function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
    return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/dff.sv
// Single D flop with synchronous active-high reset to a parametrised value.
module dff #(
  parameter logic reset_val_p = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic q_d, q_q;

  always_comb begin
    q_d = reset_i ? reset_val_p : d_i;
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/input_conditioner_channel.sv
// One channel: synchronizer chain, polarity normalisation, debounce counter and edge pulses.
module input_conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned sync_stages_p     = 2,
  parameter int unsigned debounce_cycles_p = 250000,
  parameter logic        idle_p            = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned cnt_w_lp = cnt_width(debounce_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(debounce_cycles_p - 1);

  logic [sync_stages_p-1:0] sync_chain;
  logic [sync_stages_p-1:0] sync_in;
  logic                     s;

  assign sync_in = {sync_chain[sync_stages_p-2:0], raw_i};

  // Stages reset to the idle level so reset never looks like an assertion
  for (genvar k = 0; k < sync_stages_p; k++) begin : g_sync
    dff #(.reset_val_p(idle_p)) u_stage (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .d_i    (sync_in[k]),
      .q_o    (sync_chain[k])
    );
  end

  assign s = sync_chain[sync_stages_p-1] ^ idle_p;

  logic                st_d,  st_q;
  logic [cnt_w_lp-1:0] cnt_d, cnt_q;
  logic                rise_d, rise_q;
  logic                fall_d, fall_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (reset_i) begin
      st_d  = 1'b0;
      cnt_d = '0;
    end else if (s == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == cnt_last_lp) begin
      st_d   = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    st_q   <= st_d;
    cnt_q  <= cnt_d;
    rise_q <= rise_d;
    fall_q <= fall_d;
  end

  assign level_o = st_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel pad input conditioner: independent debounced channels plus an any-asserted flag.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned        width_p           = 3,
  parameter int unsigned        sync_stages_p     = 2,
  parameter int unsigned        debounce_cycles_p = 250000,
  parameter logic [width_p-1:0] idle_p            = '1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] async_unsafe_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] rise_o,
  output logic [width_p-1:0] fall_o,
  output logic               any_o
);

  if (width_p < min_width_lp) begin : g_bad_width
    $error("input_conditioner: width_p must be >= 1");
  end
  if (sync_stages_p < min_sync_stages_lp) begin : g_bad_sync
    $error("input_conditioner: sync_stages_p must be >= 2");
  end
  if (debounce_cycles_p < min_debounce_lp) begin : g_bad_debounce
    $error("input_conditioner: debounce_cycles_p must be >= 1");
  end

  for (genvar i = 0; i < width_p; i++) begin : g_chan
    input_conditioner_channel #(
      .sync_stages_p    (sync_stages_p),
      .debounce_cycles_p(debounce_cycles_p),
      .idle_p           (idle_p[i])
    ) u_chan (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .raw_i  (async_unsafe_i[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

  assign any_o = |level_o;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: window-based reference model, directed scenarios, random bounce.
module tb_input_conditioner;

  localparam int unsigned W = 3;
  localparam int unsigned S = 2;
  localparam int unsigned D = 4;
  localparam logic [W-1:0] IDLE = 3'b001;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw = IDLE;
  logic [W-1:0] level, rise, fall;
  logic         any;

  int checks = 0;
  int failures = 0;
  int rise_cnt [W];
  int fall_cnt [W];

  exp_t         exp_q [$];
  logic [W-1:0] rq [$];
  logic [W-1:0] sq [$];
  logic [W-1:0] m_level = '0;

  input_conditioner #(
    .width_p          (W),
    .sync_stages_p    (S),
    .debounce_cycles_p(D),
    .idle_p           (IDLE)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .async_unsafe_i(raw),
    .level_o       (level),
    .rise_o        (rise),
    .fall_o        (fall),
    .any_o         (any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  // A channel flips once its last D normalised sync samples all disagree with its level
  function automatic bit steady(input int unsigned ch, input logic v);
    if (sq.size() < D) return 1'b0;
    foreach (sq[k]) if (sq[k][ch] !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    exp_t         e;
    logic [W-1:0] sync_out;
    e = '0;
    if (reset) begin
      rq.delete();
      sq.delete();
      m_level = '0;
    end else begin
      sync_out = (rq.size() == S) ? rq[0] : IDLE;
      rq.push_back(raw);
      if (rq.size() > S) void'(rq.pop_front());
      sq.push_back(sync_out ^ IDLE);
      if (sq.size() > D) void'(sq.pop_front());
      for (int i = 0; i < W; i++) begin
        if (steady(i, ~m_level[i])) begin
          m_level[i] = ~m_level[i];
          if (m_level[i]) e.rise[i] = 1'b1;
          else            e.fall[i] = 1'b1;
        end
      end
    end
    e.level = m_level;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    exp_t e;
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_level", level, e.level);
        check("sb_rise",  rise,  e.rise);
        check("sb_fall",  fall,  e.fall);
        check("sb_any",   {2'b00, any}, {2'b00, |e.level});
        check("sb_excl",  rise & fall, '0);
        for (int i = 0; i < W; i++) begin
          if (rise[i] === 1'b1) rise_cnt[i]++;
          if (fall[i] === 1'b1) fall_cnt[i]++;
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] r, input logic rs, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      raw   = r;
      reset = rs;
    end
  endtask

  initial begin
    int r0;
    logic [W-1:0] r;

    // Reset with idle inputs, then a quiet stretch
    drive(IDLE, 1'b1, 3);
    drive(IDLE, 1'b0, 22);
    check("rst_level", level, '0);
    check("rst_pulses", W'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] +
                           fall_cnt[0] + fall_cnt[1] + fall_cnt[2]), '0);

    // Clean press on bit1: accepted on exactly the sixth edge
    @(negedge clk);
    raw = 3'b011;
    repeat (5) @(posedge clk);
    #1 check("press_early", {2'b00, level[1]}, 3'b000);
    @(posedge clk);
    #1 check("press_level", level, 3'b010);
    check("press_rise", rise, 3'b010);
    check("press_any", {2'b00, any}, 3'b001);
    @(posedge clk);
    #1 check("press_rise_once", rise, 3'b000);

    // Active-low bit0
    drive(3'b010, 1'b0, 10);
    check("al_level", level, 3'b011);
    check("al_rise", W'(rise_cnt[0]), 3'd1);
    drive(3'b011, 1'b0, 10);
    check("al_release", level, 3'b010);
    check("al_fall", W'(fall_cnt[0]), 3'd1);

    // Bounce on bit2 is rejected, then a 4-cycle hold is accepted
    drive(3'b111, 1'b0, 3);
    drive(3'b011, 1'b0, 1);
    drive(3'b111, 1'b0, 3);
    drive(3'b011, 1'b0, 8);
    check("bounce_level", {2'b00, level[2]}, 3'b000);
    check("bounce_pulses", W'(rise_cnt[2] + fall_cnt[2]), 3'd0);
    drive(3'b111, 1'b0, 4);
    drive(3'b011, 1'b0, 12);
    check("hold4_rise", W'(rise_cnt[2]), 3'd1);
    check("hold4_fall", W'(fall_cnt[2]), 3'd1);

    // Release bit1, then press bits 1 and 2 together while bit0 chatters
    drive(3'b001, 1'b0, 10);
    check("sim_idle", level, 3'b000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      raw = {2'b11, k[0]};
      @(posedge clk);
      #1;
      if (k == 5) check("sim_rise", rise, 3'b110);
      check("sim_bit0", {2'b00, level[0]}, 3'b000);
    end
    drive(3'b001, 1'b0, 12);

    // Reset at count 3 on bit1, released while the pad is still held
    r0 = rise_cnt[1];
    @(negedge clk);
    raw = 3'b011;
    repeat (5) @(posedge clk);
    drive(3'b011, 1'b1, 3);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_nopulse", W'(rise_cnt[1] - r0), 3'd0);
    repeat (5) @(posedge clk);
    #1 check("midrst_wait", {2'b00, rise[1]}, 3'b000);
    @(posedge clk);
    #1 check("midrst_rise", rise, 3'b010);
    drive(3'b001, 1'b0, 10);

    // Random bouncing with occasional resets
    r = IDLE;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      end
      drive(r, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1);
    end
    drive(r, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel conditioner for asynchronous, un-debounced board inputs such as push-buttons and mode straps. Each channel gets an N-stage synchronizer, polarity normalisation, and a debounce counter. It produces a clean level plus single-cycle rise and fall pulses. It sits directly behind the top-level pads, generalises the fixed two-flop reset synchronizer to any width, depth and polarity, and feeds the debounced buttons to the UART/AXIS datapath.

## Interface
- `width_p`, default 3: number of independent channels; must be ≥1.
- `sync_stages_p`, default 2: synchronizer flops per channel; must be ≥2.
- `debounce_cycles_p`, default 250000 (10 ms at 25 MHz): consecutive stable cycles required to accept a change; must be ≥1.
- `idle_p`, default all-ones (`width_p` bits): raw idle level per channel. A bit of 1 means active-low.
- `clk_i` in 1: sole clock.
- `reset_i` in 1: synchronous, active-high reset.
- `async_unsafe_i` in `width_p`: raw pad inputs; asynchronous, may bounce.
- `level_o` out `width_p`: debounced state, 1 = asserted (not idle).
- `rise_o` out `width_p`: one-cycle pulse when `level_o[i]` goes 0→1.
- `fall_o` out `width_p`: one-cycle pulse when `level_o[i]` goes 1→0.
- `any_o` out 1: OR of `level_o`.

## Operation
Channels are fully independent. The following applies per channel i.
- **Sync chain**
  - `sync_stages_p` flops in series.
  - Reset value of every stage is `idle_p[i]`, so reset cannot produce a false assertion.
  - Normalised sample: `s = sync_out ^ idle_p[i]` (1 = asserted).
- **Debounce**
  - Stable register `st` drives `level_o[i]`.
  - Counter `cnt` is `$clog2(debounce_cycles_p+1)` bits wide.
  - If `s == st`: `cnt ← 0`.
  - If `s != st` and `cnt == debounce_cycles_p-1`: `st ← s`, `cnt ← 0`, and assert `rise_o`/`fall_o` as appropriate.
  - Otherwise: `cnt ← cnt+1`.
  - `cnt` never exceeds `debounce_cycles_p-1`, so there is no wrap-around.
- **Glitch rejection:** any disagreement lasting fewer than `debounce_cycles_p` consecutive cycles clears `cnt` and leaves `st` unchanged.
- **Pulses**
  - Registered, high for exactly the one cycle in which `level_o[i]` first shows its new value.
  - `rise_o[i]` and `fall_o[i]` are never high together.
- **Reset**
  - Values: `st=0`, `cnt=0`, `rise_o=fall_o=0`, `level_o=0`, `any_o=0`, sync stages = `idle_p`.
  - Reset mid-count discards the partial count.
  - If the pad is asserted while `reset_i` is high, the channel asserts normally (with a `rise_o` pulse) after full latency from reset release.
- `any_o` is combinational OR of the registered `level_o`.

## Timing
- Raw change captured at clock edge 1. Sync output shows it after edge `sync_stages_p` (S).
- `level_o` and the pulse change after edge S+D, where D = `debounce_cycles_p`. Latency is S+D cycles.
- With D=1, `level_o` follows the synchronizer output one cycle later. There is no filtering.
- A toggle back before edge S+D restarts the count. Minimum accepted pulse width is D cycles at the sync output.
- Consecutive accepted edges are at least D cycles apart, so pulses on one channel are at least D cycles apart.
- Reset takes effect at the first edge with `reset_i=1`. Outputs are 0 in the following cycle.

## Structure
- Package `input_conditioner_pkg`:
  - Function computing counter width from `debounce_cycles_p`.
  - Elaboration-time assertions: `width_p≥1`, `sync_stages_p≥2`, `debounce_cycles_p≥1`.
  - No typedefs are needed beyond the counter width.
- One natural sub-module, `input_conditioner_channel`:
  - Contains the sync chain, debounce counter and pulse logic for one bit.
  - Instantiated `width_p` times in a generate loop.
  - The top level adds only `any_o`.
- Sync stages are built from the team's existing `dff` cell, with a parametrised reset value.

## Test plan
Config for all tests: `width_p=3`, `sync_stages_p=2`, `debounce_cycles_p=4`, `idle_p=3'b001`.
- **Reset values:** hold `reset_i` 3 cycles with inputs 3'b001 → `level_o=0`, `rise_o=fall_o=0`, `any_o=0` throughout and after release. No spurious pulse for 20 cycles.
- **Clean press:** drive bit1 high and hold → `level_o[1]=1` exactly 6 edges later, `rise_o[1]` high that cycle only, `any_o=1`.
- **Active-low channel:** drive bit0 low and hold → `level_o[0]=1` after 6 edges. Return bit0 high → `fall_o[0]` one cycle, `level_o[0]=0` after 6 edges.
- **Bounce rejection:** on bit2, toggle high 3 cycles, low 1, high 3, then low → `level_o[2]` stays 0, no pulses. Then hold high 4 cycles at the sync output → accepted.
- **Simultaneous and independent channels:** press bit1 and bit2 on the same edge while bit0 bounces → `rise_o=3'b110` in a single cycle, bit0 unaffected.
- **Reset mid-count:** bit1 high, assert `reset_i` at count 3, release while still high → no pulse during reset. `rise_o[1]` occurs 6 edges after release.
